// File: rtl/aes_pkg.sv
// Shared AES constants, key-schedule state encoding and GF(2^8) helpers.
package aes_pkg;

    localparam int unsigned AES_NR        = 10;
    localparam logic [7:0]  AES_RCON_INIT = 8'h01;
    localparam int unsigned KEY_W         = 128;
    localparam int unsigned WORD_W        = 32;
    localparam int unsigned IDX_W         = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1
    } ks_state_e;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) multiply by shift-and-add.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion round: derives round key i+1 from round key i.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [KEY_W-1:0] cur,
    input  logic [7:0]       rcon,
    output logic [KEY_W-1:0] next
);

    logic [WORD_W-1:0] w0, w1, w2, w3;
    logic [WORD_W-1:0] rot, sub, t;
    logic [WORD_W-1:0] n0, n1, n2, n3;

    assign w0  = cur[127:96];
    assign w1  = cur[95:64];
    assign w2  = cur[63:32];
    assign w3  = cur[31:0];
    assign rot = {w3[23:0], w3[31:24]};

    aes_subword u_subword (
        .w (rot),
        .s (sub)
    );

    // Chained word XORs of the standard expansion.
    always_comb begin
        t    = sub ^ {rcon, 24'h0};
        n0   = w0 ^ t;
        n1   = w1 ^ n0;
        n2   = w2 ^ n1;
        n3   = w3 ^ n2;
        next = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] s
);

    logic [7:0] p2, p4, p8, p16, p32, p64, p128;
    logic [7:0] inv;

    // Inverse as a^254 = a^2 * a^4 * ... * a^128 (maps 0 to 0 as required).
    always_comb begin
        p2   = gf_mul(a, a);
        p4   = gf_mul(p2, p2);
        p8   = gf_mul(p4, p4);
        p16  = gf_mul(p8, p8);
        p32  = gf_mul(p16, p16);
        p64  = gf_mul(p32, p32);
        p128 = gf_mul(p64, p64);
        inv  = gf_mul(gf_mul(gf_mul(p2, p4), gf_mul(p8, p16)),
                      gf_mul(gf_mul(p32, p64), p128));
    end

    // Affine transform: inv ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
    always_comb begin
        s = inv
          ^ {inv[6:0], inv[7]}
          ^ {inv[5:0], inv[7:6]}
          ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]}
          ^ 8'h63;
    end

endmodule

// File: rtl/aes_subword.sv
// SubWord: S-box applied to each byte of a 32-bit word.
module aes_subword
    import aes_pkg::*;
(
    input  logic [WORD_W-1:0] w,
    output logic [WORD_W-1:0] s
);

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .a (w[8*g +: 8]),
            .s (s[8*g +: 8])
        );
    end

endmodule

// File: rtl/aes_key_scheduler.sv
// Sequential AES-128 key schedule: accepts one key, streams round keys 0..NR.
module aes_key_scheduler
    import aes_pkg::*;
#(
    parameter int unsigned NR = AES_NR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [KEY_W-1:0] key,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [KEY_W-1:0] rk,
    output logic [IDX_W-1:0] rk_idx,
    output logic             rk_last,
    output logic             busy
);

    if (NR != AES_NR) begin : g_nr_check
        $error("aes_key_scheduler supports only NR == 10 (AES-128)");
    end

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR);

    ks_state_e        state_q, state_d;
    logic [KEY_W-1:0] cur_q, cur_d, cur_next;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       rcon_q, rcon_d;
    logic             key_ready_d, rk_valid_d, rk_last_d, busy_d;

    aes_key_step u_step (
        .cur  (cur_q),
        .rcon (rcon_q),
        .next (cur_next)
    );

    // Next-state, datapath and output-flag logic.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        idx_d   = idx_q;
        rcon_d  = rcon_q;
        unique case (state_q)
            IDLE: begin
                if (key_valid && key_ready) begin
                    state_d = EMIT;
                    cur_d   = key;
                    idx_d   = '0;
                    rcon_d  = AES_RCON_INIT;
                end
            end
            EMIT: begin
                if (rk_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        cur_d  = cur_next;
                        idx_d  = idx_q + IDX_W'(1);
                        rcon_d = xtime(rcon_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        key_ready_d = (state_d == IDLE);
        rk_valid_d  = (state_d == EMIT);
        busy_d      = (state_d == EMIT);
        rk_last_d   = (state_d == EMIT) && (idx_d == LAST_IDX);
    end

    // State, datapath and registered handshake flags; reset is synchronous.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cur_q     <= '0;
            idx_q     <= '0;
            rcon_q    <= '0;
            key_ready <= 1'b1;
            rk_valid  <= 1'b0;
            rk_last   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            idx_q     <= idx_d;
            rcon_q    <= rcon_d;
            key_ready <= key_ready_d;
            rk_valid  <= rk_valid_d;
            rk_last   <= rk_last_d;
            busy      <= busy_d;
        end
    end

    assign rk     = cur_q;
    assign rk_idx = idx_q;

endmodule

// File: tb/tb_aes_key_scheduler.sv
// Self-checking bench for aes_key_scheduler against a table-driven key expansion model.
module tb_aes_key_scheduler;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk;
    logic [3:0]   rk_idx;
    logic         rk_last;
    logic         busy;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]   sbox_m [0:255];
    logic [7:0]   rcon_m [1:10];
    logic [127:0] exp_rk [0:10];
    logic [127:0] obs_rk [0:10];

    aes_key_scheduler #(.NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key       (key),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk        (rk),
        .rk_idx    (rk_idx),
        .rk_last   (rk_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int unsigned x, y, p;
        x = a; y = b; p = 0;
        while (y != 0) begin
            if (y % 2 == 1) p = p ^ x;
            x = x * 2;
            if (x >= 256) x = x ^ 'h11b;
            y = y / 2;
        end
        return 8'(p);
    endfunction

    task automatic build_tables();
        logic [7:0] inv, c63, sb, r;
        c63 = 8'h63;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++)
                if (gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
            for (int i = 0; i < 8; i++)
                sb[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c63[i];
            sbox_m[a] = sb;
        end
        r = 8'h01;
        for (int i = 1; i <= 10; i++) begin
            rcon_m[i] = r;
            r = gmul(r, 8'h02);
        end
    endtask

    task automatic expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t = t ^ {rcon_m[i/4], 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " key_ready"}, 128'(key_ready), 128'd1);
        chk({tag, " rk_valid"},  128'(rk_valid),  128'd0);
        chk({tag, " busy"},      128'(busy),      128'd0);
    endtask

    // Offer a key for one cycle while idle; returns at posedge+1 after the capture edge.
    task automatic accept(input logic [127:0] k);
        key       = k;
        key_valid = 1'b1;
        @(negedge clk);
        check_idle_outputs("accept");
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    // Consume beats, checking each cycle against the model; optional reset abort or key injection.
    task automatic stream(input bit rnd, input int abort_idx, input int inject_at,
                          input logic [127:0] other, output int cycles);
        int beat;
        bit done;
        beat = 0; done = 1'b0; cycles = 0;
        while (!done && cycles < 300) begin
            rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cycles == inject_at) begin
                key_valid = 1'b1;
                key       = other;
            end else begin
                key_valid = 1'b0;
            end
            @(negedge clk);
            chk("beat rk_valid",  128'(rk_valid),     128'd1);
            chk("beat key_ready", 128'(key_ready),    128'd0);
            chk("beat busy",      128'(busy),         128'd1);
            chk("beat rk_idx",    128'(rk_idx),       128'(beat));
            chk("beat rk",        rk,                 exp_rk[beat]);
            chk("beat rk_last",   128'(rk_last),      128'(beat == 10));
            if (beat == abort_idx) begin
                rst_n = 1'b0;
                done  = 1'b1;
            end else if (rk_ready) begin
                obs_rk[beat] = rk;
                if (beat == 10) done = 1'b1;
                beat++;
            end
            cycles++;
            @(posedge clk); #1;
        end
        key_valid = 1'b0;
        rk_ready  = 1'b0;
        if (!done) chk("stream timeout", 128'd0, 128'd1);
    endtask

    initial begin
        logic [127:0] k, k2;
        int cyc;

        rst_n = 1'b0; key_valid = 1'b0; rk_ready = 1'b0; key = '0;
        build_tables();

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        chk("reset rk",      rk,              128'd0);
        chk("reset rk_idx",  128'(rk_idx),    128'd0);
        chk("reset rk_last", 128'(rk_last),   128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // FIPS-197 key, no backpressure.
        k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        expand(k);
        accept(k);
        stream(1'b0, -1, -1, '0, cyc);
        chk("fips cycles", 128'(cyc), 128'd11);
        chk("fips idx1",  obs_rk[1],  128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips idx10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Second known key; key_ready must be high 12 cycles after acceptance.
        k = 128'h000102030405060708090a0b0c0d0e0f;
        expand(k);
        accept(k);
        stream(1'b0, -1, -1, '0, cyc);
        chk("seq cycles", 128'(cyc), 128'd11);
        chk("seq idx0",  obs_rk[0],  128'h000102030405060708090a0b0c0d0e0f);
        chk("seq idx10", obs_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        @(negedge clk);
        check_idle_outputs("after seq");
        @(posedge clk); #1;

        // Random keys with random backpressure.
        for (int n = 0; n < 4; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            expand(k);
            accept(k);
            stream(1'b1, -1, -1, '0, cyc);
        end

        // Key pulsed during EMIT is ignored; then a back-to-back key is accepted.
        k  = {$urandom, $urandom, $urandom, $urandom};
        k2 = {$urandom, $urandom, $urandom, $urandom};
        expand(k);
        accept(k);
        stream(1'b1, -1, 3, k2, cyc);
        expand(k2);
        accept(k2);
        stream(1'b0, -1, -1, '0, cyc);

        // Reset at idx 5 aborts the schedule; a fresh key restarts from round 0.
        k = {$urandom, $urandom, $urandom, $urandom};
        expand(k);
        accept(k);
        stream(1'b0, 5, -1, '0, cyc);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("abort");
        chk("abort rk",      rk,            128'd0);
        chk("abort rk_idx",  128'(rk_idx),  128'd0);
        chk("abort rk_last", 128'(rk_last), 128'd0);
        @(posedge clk); #1;
        k = {$urandom, $urandom, $urandom, $urandom};
        expand(k);
        accept(k);
        stream(1'b1, -1, -1, '0, cyc);

        // key_valid held through reset: no capture until the first edge with rst_n high.
        k = {$urandom, $urandom, $urandom, $urandom};
        expand(k);
        rst_n = 1'b0;
        key_valid = 1'b1;
        key = k;
        repeat (3) begin
            @(negedge clk);
            check_idle_outputs("rst hold");
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("rst release");
        @(posedge clk); #1;
        key_valid = 1'b0;
        stream(1'b0, -1, -1, '0, cyc);
        chk("rst release cycles", 128'(cyc), 128'd11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_key_scheduler.md
# aes_key_scheduler

Sequential AES-128 key schedule that sits directly upstream of the cipher datapath. It accepts one 128-bit cipher key over a valid/ready handshake. It then streams the 11 round keys (round 0 through round 10) one per cycle, with round index and last flag. Backpressure from the consumer is honoured. This replaces the fully unrolled 1408-bit combinational expansion with one 128-bit register and one round of key logic.

## Interface
- NR, 10, number of rounds; only 10 (AES-128) is supported, and elaboration fails on any other value.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- key_valid  input  1  cipher key offered.
- key_ready  output  1  block idle and able to accept a key.
- key  input  128  cipher key; key[127:96] is w0 and key[31:0] is w3.
- rk_valid  output  1  round key beat valid.
- rk_ready  input  1  consumer accepts the beat.
- rk  output  128  round key; same word order as key.
- rk_idx  output  4  round number of the current beat, 0..10.
- rk_last  output  1  high with rk_idx == 10.
- busy  output  1  a schedule is in progress (state EMIT).

## Operation
- State IDLE:
  - key_ready=1 and rk_valid=0.
  - On key_valid & key_ready: cur<=key, idx<=0, rcon<=8'h01, then go to EMIT.
- State EMIT:
  - key_ready=0, rk_valid=1, rk=cur, rk_idx=idx, rk_last=(idx==NR).
  - On rk_ready with idx<NR:
    - cur<=next(cur, rcon).
    - idx<=idx+1.
    - rcon<=xtime(rcon), where xtime = shift left by one, XOR 8'h1b if bit 7 was set.
  - On rk_ready with idx==NR: go to IDLE. cur, idx and rcon hold.
  - On !rk_ready: all registers hold, so rk, rk_idx and rk_last stay stable. There is no timeout.
- next(cur, rcon), with cur words w0..w3:
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}, where RotWord(w) = {w[23:0], w[31:24]}.
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
  - Result is {n0, n1, n2, n3}.
- rcon sequence: 01 02 04 08 10 20 40 80 1b 36. All arithmetic is 8-bit in GF(2^8), with no overflow beyond 8 bits.
- key_valid is ignored outside IDLE. A key presented during EMIT is not captured.
- Reset:
  - rst_n low at any clock edge forces IDLE.
  - cur, idx and rcon clear to 0.
  - rk_valid=0, rk=0, rk_idx=0, rk_last=0, busy=0, key_ready=1 on the first cycle after reset.
  - Reset mid-schedule aborts it; no further beats of that schedule appear.

## Timing
- Key accepted at edge N: round key 0 is valid in cycle N+1.
- With rk_ready held high: round key k is valid in cycle N+1+k. rk_last is high in cycle N+11. key_ready=1 in cycle N+12.
- Key-to-key throughput is 12 cycles under no backpressure. There is no overlap between consecutive keys, by design.
- rk is driven directly from the cur register (registered output). The next-key logic is one combinational round, SubWord plus four 32-bit XORs, between registers.
- Each stall cycle (rk_valid & !rk_ready) adds exactly one cycle and never drops or duplicates a beat.

## Structure
- Shared package aes_pkg holds:
  - AES_NR=10 and AES_RCON_INIT=8'h01.
  - The 2-bit state enum (IDLE, EMIT).
  - An xtime function, also used by the column-mixing logic.
- One combinational sub-module, aes_key_step: inputs cur[127:0] and rcon[7:0], output next[127:0]. It instantiates the existing subword module, which is four sbox instances.
- The top level holds the FSM, the cur, idx and rcon registers, and the handshake.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c with rk_ready=1 -> beats for idx 0..10 in consecutive cycles:
  - idx 1 = a0fafe1788542cb123a339392a6c7605.
  - idx 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, with rk_last=1.
- Key 000102030405060708090a0b0c0d0e0f -> idx 0 equals the key; idx 10 = 13111d7fe3944a17f307a78b4d2b30c5. key_ready returns high 12 cycles after acceptance.
- Random rk_ready with a 50% duty cycle -> identical 11-beat sequence. rk, rk_idx and rk_last stay stable on every stall cycle.
- key_valid pulsed during EMIT with a different key -> ignored; the current schedule completes unchanged. A back-to-back key applied when key_ready rises is accepted.
- rst_n pulled low at idx 5 -> next cycle rk_valid=0, rk=0, key_ready=1. A fresh key then restarts at idx 0 with rcon=01.
- Reset with key_valid high -> no capture during reset. Capture happens at the first edge with rst_n=1.
